// File: rtl/bf2_sdf_stage_if.sv
// Sample, shift-register and output signals of one radix-2 SDF butterfly stage.
// The stage uses the slave modport; its environment uses the master modport.
interface bf2_sdf_stage_if;
    localparam int unsigned DW = 16;

    logic                 in_valid;
    logic signed [DW-1:0] in_r;
    logic signed [DW-1:0] in_i;
    logic signed [DW-1:0] sr_r;
    logic signed [DW-1:0] sr_i;
    logic signed [DW-1:0] fb_r;
    logic signed [DW-1:0] fb_i;
    logic                 out_valid;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] out_i;
    logic                 err;

    modport master (
        output in_valid, in_r, in_i, sr_r, sr_i,
        input  fb_r, fb_i, out_valid, out_r, out_i, err
    );

    modport slave (
        input  in_valid, in_r, in_i, sr_r, sr_i,
        output fb_r, fb_i, out_valid, out_r, out_i, err
    );
endinterface

// File: rtl/bf2_sdf_stage.sv
// Radix-2 single-path delay-feedback stage, D=4, block period 8.
// Fill half stores samples and emits twiddled differences; butterfly half emits sums.
module bf2_sdf_stage (
    input  logic           clk,
    input  logic           rst_n,
    bf2_sdf_stage_if.slave bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned AW = 2 * DW + 1;
    localparam int unsigned SH = 14;

    localparam logic signed [DW-1:0] TW_ONE  = DW'(16384);
    localparam logic signed [DW-1:0] TW_DIAG = DW'(11585);
    localparam logic signed [AW-1:0] RND     = AW'(8192);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic                 r_primed, w_primed_nxt;
    logic                 r_err, w_err_nxt;
    logic                 w_active, w_flush, w_emit;

    logic                 r_out_valid;
    logic signed [DW-1:0] r_out_r, r_out_i;

    logic                 w_fill;
    logic signed [DW-1:0] w_in_r, w_in_i, w_wr, w_wi;
    logic signed [DW-1:0] w_fb_r, w_fb_i, w_tw_r, w_tw_i, w_sum_r, w_sum_i;
    logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [AW-1:0] w_acc_r, w_acc_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_primed <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_primed <= w_primed_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // The accepting IDLE cycle is slot 0 of the block; a drop at slot 0 is flush slot 0.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_primed_nxt = r_primed;
        w_err_nxt    = r_err;
        w_active     = 1'b0;
        w_flush      = 1'b0;
        w_emit       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid && rst_n) begin
                    w_active     = 1'b1;
                    w_state_nxt  = RUN;
                    w_cnt_nxt    = CW'(1);
                    w_primed_nxt = 1'b0;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    w_active  = 1'b1;
                    w_emit    = r_cnt[2] | r_primed;
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == CW'(4)) w_primed_nxt = 1'b1;
                end else if (r_cnt == '0) begin
                    w_active    = 1'b1;
                    w_flush     = 1'b1;
                    w_emit      = 1'b1;
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end
            end
            FLUSH: begin
                w_active = 1'b1;
                w_flush  = 1'b1;
                w_emit   = 1'b1;
                if (r_cnt == CW'(3)) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_fill = ~r_cnt[2];
    assign w_in_r = w_flush ? '0 : bus.in_r;
    assign w_in_i = w_flush ? '0 : bus.in_i;

    // Q1.14 twiddles W8^k, k = cnt[1:0]
    always_comb begin
        w_wr = TW_ONE;
        w_wi = '0;
        unique case (r_cnt[1:0])
            2'd0: begin w_wr = TW_ONE;   w_wi = '0;       end
            2'd1: begin w_wr = TW_DIAG;  w_wi = -TW_DIAG; end
            2'd2: begin w_wr = '0;       w_wi = -TW_ONE;  end
            default: begin w_wr = -TW_DIAG; w_wi = -TW_DIAG; end
        endcase
    end

    assign w_p_rr  = PW'(bus.sr_r) * PW'(w_wr);
    assign w_p_ii  = PW'(bus.sr_i) * PW'(w_wi);
    assign w_p_ri  = PW'(bus.sr_r) * PW'(w_wi);
    assign w_p_ir  = PW'(bus.sr_i) * PW'(w_wr);
    assign w_acc_r = AW'(w_p_rr) - AW'(w_p_ii) + RND;
    assign w_acc_i = AW'(w_p_ri) + AW'(w_p_ir) + RND;
    assign w_tw_r  = DW'(w_acc_r >>> SH);
    assign w_tw_i  = DW'(w_acc_i >>> SH);

    assign w_sum_r = bus.sr_r + w_in_r;
    assign w_sum_i = bus.sr_i + w_in_i;

    assign w_fb_r = !w_active ? '0 : (w_fill ? w_in_r : bus.sr_r - w_in_r);
    assign w_fb_i = !w_active ? '0 : (w_fill ? w_in_i : bus.sr_i - w_in_i);

    // Output holds its last value whenever nothing valid was computed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_r     <= '0;
            r_out_i     <= '0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_r <= w_fill ? w_tw_r : w_sum_r;
                r_out_i <= w_fill ? w_tw_i : w_sum_i;
            end
        end
    end

    assign bus.fb_r      = w_fb_r;
    assign bus.fb_i      = w_fb_i;
    assign bus.out_valid = r_out_valid;
    assign bus.out_r     = r_out_r;
    assign bus.out_i     = r_out_i;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_bf2_sdf_stage.sv
// Directed bench for bf2_sdf_stage with an external 4-deep feedback shift register.
// Expected values are hand-derived constants and simple closed-form ramp sums.
module tb_bf2_sdf_stage;
    logic clk;
    logic rst_n;

    bf2_sdf_stage_if bus ();

    bf2_sdf_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External delay line closing the feedback loop, with an override for corner cases
    logic signed [15:0] sreg_r [4];
    logic signed [15:0] sreg_i [4];
    logic               ov_en;
    logic signed [15:0] ov_r, ov_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                sreg_r[i] <= '0;
                sreg_i[i] <= '0;
            end
        end else begin
            sreg_r[0] <= bus.fb_r;
            sreg_i[0] <= bus.fb_i;
            for (int i = 1; i < 4; i++) begin
                sreg_r[i] <= sreg_r[i-1];
                sreg_i[i] <= sreg_i[i-1];
            end
        end
    end

    always_comb begin
        bus.sr_r = ov_en ? ov_r : sreg_r[3];
        bus.sr_i = ov_en ? ov_i : sreg_i[3];
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int h_r    = 0;
    int h_i    = 0;
    logic e_err = 1'b0;

    // Twiddled (-4,0) and (-4,4) differences for k = 0..3
    int rt_r [4] = '{-4, -3, 0, 3};
    int rt_i [4] = '{ 0,  3, 4, 3};
    int ct_r [4] = '{-4,  0, 4, 6};
    int ct_i [4] = '{ 4,  6, 4, 0};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // One cycle: drive at posedge+1, check fb at +2, check registered outputs at next posedge+1
    task automatic cyc(input string tag, input logic v, input int ir, input int ii,
                       input int efr, input int efi, input logic eov, input int eor, input int eoi);
        bus.in_valid = v;
        bus.in_r     = 16'(ir);
        bus.in_i     = 16'(ii);
        #1;
        chk($sformatf("%s.fb_r", tag), bus.fb_r, 16'(efr));
        chk($sformatf("%s.fb_i", tag), bus.fb_i, 16'(efi));
        @(posedge clk);
        #1;
        if (eov) begin
            h_r = eor;
            h_i = eoi;
        end
        chk($sformatf("%s.out_valid", tag), 16'(bus.out_valid), 16'(eov));
        chk($sformatf("%s.out_r", tag), bus.out_r, 16'(h_r));
        chk($sformatf("%s.out_i", tag), bus.out_i, 16'(h_i));
        chk($sformatf("%s.err", tag), 16'(bus.err), 16'(e_err));
    endtask

    task automatic run_ramp(input int n_flush);
        for (int j = 0; j < 8; j++)
            cyc("ramp", 1'b1, j + 1, 0, (j < 4) ? j + 1 : -4, 0, j >= 4, 2 * j - 2, 0);
        for (int k = 0; k < n_flush; k++)
            cyc("ramp_flush", 1'b0, 99, -99, 0, 0, 1'b1, rt_r[k], rt_i[k]);
    endtask

    task automatic run_cont();
        int b, j, x, s;
        for (int n = 0; n < 32; n++) begin
            b = n / 8;
            j = n % 8;
            x = n + 1;
            s = 16 * b + 2 * j - 2;
            if (j < 4) cyc("cont_fill", 1'b1, x, -x, x, -x, b > 0, ct_r[j % 4], ct_i[j % 4]);
            else       cyc("cont_bfly", 1'b1, x, -x, -4, 4, 1'b1, s, -s);
        end
        for (int k = 0; k < 4; k++)
            cyc("cont_flush", k > 0, 777, -777, 0, 0, 1'b1, ct_r[k], ct_i[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        ov_en        = 1'b0;
        ov_r         = '0;
        ov_i         = '0;
        bus.in_valid = 1'b0;
        bus.in_r     = '0;
        bus.in_i     = '0;
        #2;
        chk("rst.out_valid", 16'(bus.out_valid), 16'(0));
        chk("rst.out_r", bus.out_r, 16'(0));
        chk("rst.out_i", bus.out_i, 16'(0));
        chk("rst.err", 16'(bus.err), 16'(0));
        bus.in_valid = 1'b1;
        bus.in_r     = 16'(5);
        bus.in_i     = 16'(5);
        #1;
        chk("rst.fb_r", bus.fb_r, 16'(0));
        chk("rst.fb_i", bus.fb_i, 16'(0));
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ramp block, then a continuous frame starting on the cycle right after flush
        run_ramp(4);
        run_cont();
        cyc("idle", 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);

        // Mid-block drop at cnt=5
        for (int j = 0; j < 5; j++)
            cyc("drop", 1'b1, 100 + j, 50 + j, (j < 4) ? 100 + j : -4, (j < 4) ? 50 + j : -4,
                j == 4, 204, 104);
        e_err = 1'b1;
        cyc("drop_lo", 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
        cyc("drop_idle", 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
        cyc("drop_idle", 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);

        // 16-bit wrap on the butterfly sum
        for (int j = 0; j < 4; j++)
            cyc("wrap_fill", 1'b1, 10 * (j + 1), 0, 10 * (j + 1), 0, 1'b0, 0, 0);
        ov_en = 1'b1;
        ov_r  = 16'sh7FFF;
        ov_i  = -16'sh8000;
        cyc("wrap", 1'b1, 1, -1, 32766, -32767, 1'b1, -32768, 32767);
        ov_en = 1'b0;
        cyc("wrap_drop", 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);

        // Asynchronous reset in the middle of flush, then a clean restart
        run_ramp(2);
        bus.in_valid = 1'b0;
        bus.in_r     = '0;
        bus.in_i     = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 16'(bus.out_valid), 16'(0));
        chk("arst.out_r", bus.out_r, 16'(0));
        chk("arst.out_i", bus.out_i, 16'(0));
        chk("arst.err", 16'(bus.err), 16'(0));
        chk("arst.fb_r", bus.fb_r, 16'(0));
        chk("arst.fb_i", bus.fb_i, 16'(0));
        h_r   = 0;
        h_i   = 0;
        e_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_ramp(4);
        cyc("final_idle", 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bf2_sdf_stage.md
BF2_SDF_STAGE -- requirements
Module: bf2_sdf_stage

Interface
REQ-001 Parameters: none; delay depth fixed at D=4 (pairs with 4-deep complex shift register), block period 8.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  input sample qualifier.
REQ-005 in_r, in_i  in  16 each  input sample, two's complement.
REQ-006 sr_r, sr_i  in  16 each  delayed sample returning from the external 4-deep shift register output.
REQ-007 fb_r, fb_i  out  16 each  combinational feedback driven into the external shift register input.
REQ-008 out_valid  out  1  registered output qualifier.
REQ-009 out_r, out_i  out  16 each  registered stage output, two's complement.
REQ-010 err  out  1  sticky protocol-error flag.

Function
REQ-011 FSM states: IDLE, RUN, FLUSH.
- Internal counter: 3-bit cnt.
- Internal flag: primed.
REQ-012 IDLE -> RUN on in_valid=1.
- cnt=0 on the accepting cycle.
- primed cleared on entry to RUN.
REQ-013 RUN: cnt increments by 1 (mod 8) every cycle.
- in_valid=0 at cnt==0: -> FLUSH.
- in_valid=0 at cnt!=0: -> IDLE, err set.
REQ-014 FLUSH: runs cnt 0..3 with input treated as zero, then -> IDLE.
- in_valid ignored in FLUSH.
REQ-015 cnt<4 (fill phase), feedback and output:
- fb = in (zero in FLUSH).
- next out = sr * W8^k, k=cnt[1:0].
REQ-016 cnt>=4 (butterfly phase), feedback and output:
- fb = sr - in.
- next out = sr + in.
REQ-017 In IDLE, fb = 0.
REQ-018 Twiddles, Q1.14 (re, im):
- W0 = (16384, 0).
- W1 = (11585, -11585).
- W2 = (0, -16384).
- W3 = (-11585, -11585).
REQ-019 Complex multiply:
- re = sr_r*wr - sr_i*wi; im = sr_r*wi + sr_i*wr, in full 33-bit precision.
- Then add 8192, arithmetic shift right 14, keep low 16 bits.
REQ-020 Butterfly add/sub is 16-bit wrap-around; no saturation, no scaling.
REQ-021 primed sets when RUN reaches cnt==4.
REQ-022 out_valid (registered) is 1 only for values computed in:
- RUN with cnt>=4;
- RUN with cnt<4 and primed=1;
- FLUSH.
REQ-023 Latency: output for a cycle's computation appears on the next rising edge.
- Sum of x[n], x[n+4] is visible 1 cycle after x[n+4] accepted.
- Twiddled difference is visible 5 cycles after x[n+4].
REQ-024 out_r/out_i hold their last value when out_valid=0.
REQ-025 A frame of 32 samples = 4 contiguous blocks; no frame-level state beyond cnt.
REQ-026 FLUSH -> IDLE and IDLE -> RUN may occur on consecutive cycles without gap.

Reset
REQ-027 On rst_n=0 (asynchronous), all outputs and state clear:
- state=IDLE, cnt=0, primed=0.
- out_valid=0, out_r=out_i=0, err=0.
REQ-028 fb_r/fb_i = 0 during reset (IDLE decode).
REQ-029 Reset mid-RUN or mid-FLUSH aborts immediately; no partial output after release.
REQ-030 err clears only by reset.

Verification
REQ-031 Ramp: real inputs 1..8 in one block (in_i=0), then in_valid=0.
- Cycles after samples 5..8: out = 6, 8, 10, 12, out_valid=1.
- FLUSH outputs: (-4,0), (-3,3), (0,4), (3,3).
- Then out_valid=0.
REQ-032 Priming: first 4 output cycles after IDLE->RUN have out_valid=0 regardless of sr values.
REQ-033 Mid-block drop: in_valid low at cnt=5.
- err=1 next cycle, out_valid=0 thereafter.
- err remains 1 until reset.
REQ-034 Continuous: 32 samples, 4 blocks back-to-back.
- out_valid continuous from sample 5 through 4 FLUSH cycles.
- fb on every cycle matches REQ-015/016.
REQ-035 Wrap: sr=32767, in=1 at cnt=4 -> out_r=-32768.
REQ-036 Async reset asserted mid-FLUSH -> all outputs 0 within the same cycle; restart succeeds.
